// File: rtl/v_fifo_pkg.sv
// Shared types and helpers for the vector FIFO reader.
//   reader_state_t : reader FSM encoding (IDLE, STREAM)
//   chunks_per_vec : number of FIFO reads needed for one full vector
package v_fifo_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } reader_state_t;

  function automatic int unsigned chunks_per_vec(input int unsigned vec_elements,
                                                 input int unsigned elements_per_read);
    return vec_elements / elements_per_read;
  endfunction

endpackage

// File: rtl/v_fifo_reader_if.sv
// Chunk stream from the FIFO reader to a downstream compute stage.
//   data  : one chunk (ElementsPerRead elements)
//   valid : data/first/last are meaningful
//   ready : consumer accepts the chunk this cycle
//   first : chunk 0 of a vector
//   last  : final chunk of a vector
interface v_fifo_reader_if #(
  parameter int unsigned Width = 32
);

  logic [Width-1:0] data;
  logic             valid;
  logic             ready;
  logic             first;
  logic             last;

  modport master (
    output data,
    output valid,
    output first,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  first,
    input  last,
    output ready
  );

endinterface

// File: rtl/v_fifo_reader.sv
// Read-side controller for a vector FIFO. Counts vectors committed by the writer and streams
// them chunk by chunk over a valid/ready interface, tagging first/last chunks.
// Ports:
//   clk_in, rst_in : clock, asynchronous active-low reset (also resets the FIFO)
//   vec_push_in    : one-cycle pulse, writer finished one full vector
//   fifo_rd_en     : advance FIFO read pointer by one chunk
//   fifo_rd_data   : combinational FIFO data at the read pointer
//   out            : registered chunk stream (master side)
//   vec_avail      : committed vectors whose last chunk has not been loaded yet
//   overflow       : sticky, push arrived with no room
//   underflow      : sticky, a load was attempted with nothing committed
module v_fifo_reader
  import v_fifo_pkg::*;
#(
  parameter int unsigned VecElements     = 8,
  parameter int unsigned ElementsPerRead = 2,
  parameter int unsigned NBits           = 16,
  parameter int unsigned Depth           = 4
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             vec_push_in,
  output logic                             fifo_rd_en,
  input  logic [ElementsPerRead*NBits-1:0] fifo_rd_data,
  v_fifo_reader_if.master                  out,
  output logic [$clog2(Depth+1)-1:0]       vec_avail,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int unsigned ChunksPerVec = chunks_per_vec(VecElements, ElementsPerRead);
  localparam int unsigned CntW         = (ChunksPerVec > 1) ? $clog2(ChunksPerVec) : 1;
  localparam int unsigned AvailW       = $clog2(Depth + 1);
  localparam int unsigned DataW        = ElementsPerRead * NBits;

  localparam logic [CntW-1:0]   LastChunk = CntW'(ChunksPerVec - 1);
  localparam logic [AvailW-1:0] Full      = AvailW'(Depth);

  if ((VecElements % ElementsPerRead) != 0) begin : g_bad_chunking
    $error("ElementsPerRead must divide VecElements");
  end

  reader_state_t     state_q, state_d;
  logic [CntW-1:0]   chunk_q, chunk_d;
  logic [AvailW-1:0] avail_q, avail_d;
  logic [DataW-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic load;
  logic last_load;
  logic push_ok;

  // A chunk is pulled whenever there is work and the output register is free or draining.
  assign load = ((state_q == STREAM) || ((state_q == IDLE) && (avail_q != '0))) &&
                (!valid_q || out.ready);
  assign last_load = load && (chunk_q == LastChunk);
  // When full, a push is still accepted if a vector finishes loading in the same cycle.
  assign push_ok = vec_push_in && ((avail_q != Full) || last_load);

  always_comb begin
    state_d     = state_q;
    chunk_d     = chunk_q;
    data_d      = data_q;
    valid_d     = valid_q;
    first_d     = first_q;
    last_d      = last_q;
    overflow_d  = overflow_q | (vec_push_in & ~push_ok);
    underflow_d = underflow_q | (load & (avail_q == '0));
    avail_d     = avail_q + AvailW'(push_ok) - AvailW'(last_load);

    if (load) begin
      data_d  = fifo_rd_data;
      valid_d = 1'b1;
      first_d = (chunk_q == '0);
      last_d  = (chunk_q == LastChunk);
      chunk_d = (chunk_q == LastChunk) ? '0 : chunk_q + CntW'(1);
    end else if (valid_q && out.ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (avail_q != '0) state_d = STREAM;
      end
      STREAM: begin
        if (last_load && (avail_d == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      chunk_q     <= '0;
      avail_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chunk_q     <= chunk_d;
      avail_q     <= avail_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign fifo_rd_en = load;
  assign out.data   = data_q;
  assign out.valid  = valid_q;
  assign out.first  = first_q;
  assign out.last   = last_q;
  assign vec_avail  = avail_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_v_fifo_reader.sv
// Bench for v_fifo_reader: a simple FIFO memory model feeds the reader, a scoreboard queue holds
// the chunks each pushed vector must produce, and a monitor pops/compares on every handshake.
module tb_v_fifo_reader;

  localparam int unsigned VecElements     = 4;
  localparam int unsigned ElementsPerRead = 2;
  localparam int unsigned NBits           = 8;
  localparam int unsigned Depth           = 2;
  localparam int unsigned ChunksPerVec    = VecElements / ElementsPerRead;
  localparam int unsigned MemElems        = Depth * VecElements;
  localparam int unsigned MemChunks       = MemElems / ElementsPerRead;

  typedef struct packed {
    logic [15:0] data;
    logic        first;
    logic        last;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        vec_push_in = 1'b0;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data;
  logic [1:0]  vec_avail;
  logic        overflow;
  logic        underflow;

  v_fifo_reader_if #(.Width(16)) out_if ();

  v_fifo_reader #(
    .VecElements    (VecElements),
    .ElementsPerRead(ElementsPerRead),
    .NBits          (NBits),
    .Depth          (Depth)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .vec_push_in (vec_push_in),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .out         (out_if),
    .vec_avail   (vec_avail),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk_in = ~clk_in;

  // FIFO model: element-addressed writes, chunk-addressed combinational reads, both wrap.
  logic [7:0]  mem [MemElems];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr;

  always_comb fifo_rd_data = {mem[rd_ptr*2+1], mem[rd_ptr*2]};

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) rd_ptr <= 0;
    else if (fifo_rd_en) rd_ptr <= (rd_ptr + 1) % MemChunks;
  end

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   delivered = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Writer side: place a vector (element i in bits 8i+:8) and, if it should come out,
  // queue its chunks. Chunk c is elements 2c (low byte) and 2c+1 (high byte).
  task automatic write_vec(input logic [31:0] elems, input bit expect_out);
    for (int i = 0; i < VecElements; i++) begin
      mem[wr_ptr] = elems[8*i +: 8];
      wr_ptr = (wr_ptr + 1) % MemElems;
    end
    if (expect_out) begin
      for (int c = 0; c < ChunksPerVec; c++) begin
        exp_t e;
        e.data  = elems[16*c +: 16];
        e.first = (c == 0);
        e.last  = (c == ChunksPerVec - 1);
        exp_q.push_back(e);
      end
      pushed++;
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    pushed = delivered;
    wr_ptr = 0;
  endtask

  // Monitor: every accepted chunk must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk_in);
      if (rst_in && out_if.valid && out_if.ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_chunk: got %0h expected none", out_if.data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("chunk_data", out_if.data, e.data);
          chk("chunk_first", out_if.first, e.first);
          chk("chunk_last", out_if.last, e.last);
          if (e.last) delivered++;
        end
      end
    end
  end

  initial begin
    logic [31:0] ra;
    int          sent;
    out_if.ready = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", out_if.valid, 0);
    chk("rst_first", out_if.first, 0);
    chk("rst_last", out_if.last, 0);
    chk("rst_data", out_if.data, 0);
    chk("rst_avail", vec_avail, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    tick();

    // Single vector, latency of two edges from push
    out_if.ready = 1'b1;
    write_vec(32'h04030201, 1'b1);
    vec_push_in = 1'b1;
    tick();
    vec_push_in = 1'b0;
    chk("single_avail_n1", vec_avail, 1);
    chk("single_valid_n1", out_if.valid, 0);
    chk("single_rd_en_n1", fifo_rd_en, 1);
    tick();
    chk("single_valid_n2", out_if.valid, 1);
    chk("single_first_n2", out_if.first, 1);
    tick();
    chk("single_last", out_if.last, 1);
    chk("single_avail_done", vec_avail, 0);
    tick();
    chk("single_idle_valid", out_if.valid, 0);
    chk("single_idle_rd_en", fifo_rd_en, 0);
    chk("single_sb_empty", exp_q.size(), 0);

    // Backpressure on the first chunk
    out_if.ready = 1'b0;
    write_vec(32'h24232221, 1'b1);
    vec_push_in = 1'b1;
    tick();
    vec_push_in = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", out_if.valid, 1);
      chk("bp_data", out_if.data, 16'h2221);
      chk("bp_first", out_if.first, 1);
      chk("bp_rd_en", fifo_rd_en, 0);
      tick();
    end
    out_if.ready = 1'b1;
    #1;
    chk("bp_release_rd_en", fifo_rd_en, 1);
    tick();
    chk("bp_chunk2_valid", out_if.valid, 1);
    chk("bp_chunk2_data", out_if.data, 16'h2423);
    tick();
    chk("bp_sb_empty", exp_q.size(), 0);

    // Back-to-back vectors: no bubble, vec_avail 1,2,1,1,0
    write_vec(32'h04030201, 1'b1);
    write_vec(32'h14131211, 1'b1);
    vec_push_in = 1'b1;
    tick();
    chk("b2b_avail_a", vec_avail, 1);
    tick();
    vec_push_in = 1'b0;
    chk("b2b_avail_b", vec_avail, 2);
    chk("b2b_valid_0", out_if.valid, 1);
    tick();
    chk("b2b_avail_c", vec_avail, 1);
    chk("b2b_valid_1", out_if.valid, 1);
    tick();
    chk("b2b_avail_d", vec_avail, 1);
    chk("b2b_valid_2", out_if.valid, 1);
    tick();
    chk("b2b_avail_e", vec_avail, 0);
    chk("b2b_valid_3", out_if.valid, 1);
    tick();
    chk("b2b_idle", out_if.valid, 0);
    chk("b2b_sb_empty", exp_q.size(), 0);

    // Push coincides with loading the last chunk of the previous vector
    ra = $urandom();
    write_vec(ra, 1'b1);
    vec_push_in = 1'b1;
    tick();
    vec_push_in = 1'b0;
    tick();
    ra = $urandom();
    write_vec(ra, 1'b1);
    vec_push_in = 1'b1;
    chk("sim_avail_pre", vec_avail, 1);
    tick();
    vec_push_in = 1'b0;
    chk("sim_avail_same", vec_avail, 1);
    chk("sim_valid", out_if.valid, 1);
    chk("sim_rd_en", fifo_rd_en, 1);
    tick();
    chk("sim_next_first", out_if.first, 1);
    chk("sim_next_valid", out_if.valid, 1);
    tick();
    chk("sim_avail_end", vec_avail, 0);
    tick();
    chk("sim_idle", out_if.valid, 0);
    chk("sim_sb_empty", exp_q.size(), 0);

    // Overflow: three pushes with nothing consumed
    out_if.ready = 1'b0;
    for (int v = 0; v < 3; v++) begin
      write_vec($urandom(), 1'b0);
      vec_push_in = 1'b1;
      tick();
      vec_push_in = 1'b0;
      tick();
      if (v == 1) begin
        chk("ovf_not_yet", overflow, 0);
        chk("ovf_avail_full", vec_avail, 2);
      end
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_avail_sat", vec_avail, 2);
    chk("ovf_unf", underflow, 0);
    #2;
    rst_in = 1'b0;
    #1;
    chk("ovf_rst_cleared", overflow, 0);
    chk("ovf_rst_avail", vec_avail, 0);
    chk("ovf_rst_valid", out_if.valid, 0);
    flush_model();
    tick();
    rst_in = 1'b1;
    tick();

    // Wrap: three vectors one at a time, the third reuses FIFO address 0
    out_if.ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      write_vec($urandom(), 1'b1);
      vec_push_in = 1'b1;
      tick();
      vec_push_in = 1'b0;
      repeat (4) tick();
      chk("wrap_avail", vec_avail, 0);
      chk("wrap_idle", out_if.valid, 0);
    end
    chk("wrap_sb_empty", exp_q.size(), 0);

    // Asynchronous reset after chunk 0 of a vector
    write_vec($urandom(), 1'b1);
    vec_push_in = 1'b1;
    tick();
    vec_push_in = 1'b0;
    tick();
    #5;
    rst_in = 1'b0;
    #1;
    chk("arst_valid", out_if.valid, 0);
    chk("arst_data", out_if.data, 0);
    chk("arst_first", out_if.first, 0);
    chk("arst_last", out_if.last, 0);
    chk("arst_avail", vec_avail, 0);
    chk("arst_rd_en", fifo_rd_en, 0);
    flush_model();
    tick();
    rst_in = 1'b1;
    tick();
    write_vec($urandom(), 1'b1);
    vec_push_in = 1'b1;
    tick();
    vec_push_in = 1'b0;
    tick();
    chk("arst_restart_valid", out_if.valid, 1);
    chk("arst_restart_first", out_if.first, 1);
    tick();
    tick();
    chk("arst_sb_empty", exp_q.size(), 0);

    // Random traffic: random backpressure and pushes, never more than Depth outstanding
    sent = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      out_if.ready = ($urandom_range(3) != 0);
      if (vec_push_in) begin
        vec_push_in = 1'b0;
      end else if (sent < 40 && (pushed - delivered) < int'(Depth) &&
                   $urandom_range(2) == 0) begin
        write_vec($urandom(), 1'b1);
        vec_push_in = 1'b1;
        sent++;
      end
      tick();
    end
    vec_push_in = 1'b0;
    out_if.ready = 1'b1;
    repeat (10) tick();
    chk("rand_sb_empty", exp_q.size(), 0);
    chk("rand_avail", vec_avail, 0);
    chk("rand_ovf", overflow, 0);
    chk("rand_unf", underflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
